apb_stream_mem: RTL and testbench

- APB-programmable pattern memory that streams DATA_W-bit words to a downstream serial transmitter (SPI/CC1200 TX path) under a valid/next handshake.
- Generalises the single-shot 12-bit/128-word test memory:
  - parametrised width and depth
  - programmable length
  - one-shot or continuous loop mode
  - software stop
  - busy/done status and a done pulse
- Sits between the APB interconnect and the SPI transmit serializer.

---
 rtl/apb_stream_mem_pkg.sv | 23 ++
 rtl/stream_mem_dpram.sv | 30 +++
 rtl/apb_stream_mem.sv | 205 ++++++++++++++++++++
 tb/tb_apb_stream_mem.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_stream_mem_pkg.sv
// Shared definitions for the APB-programmable stream pattern memory:
// register offsets, control/status bit positions and the stream FSM states.
package apb_stream_mem_pkg;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] LEN_OFS    = 32'h0000_0004;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0008;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_STOP_BIT   = 1;
    localparam int CTRL_LOOP_BIT   = 2;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_IDX_LSB  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/stream_mem_dpram.sv
// Simple dual-port pattern RAM: one synchronous write port, one registered
// read port (read-before-write on an address collision). No reset, so it
// maps onto block RAM.
module stream_mem_dpram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; a same-cycle write is seen on the following read
    always_ff @(posedge clk) begin
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/apb_stream_mem.sv
// APB-programmable pattern memory streaming DATA_W-bit words to a serial
// transmitter under a tx_en / tx_next handshake. Holds APB decode, the
// CTRL/LEN/STATUS registers and the IDLE/PRIME/RUN stream FSM.
module apb_stream_mem
    import apb_stream_mem_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 7,
    parameter int APB_AW = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       APB_S_0_paddr,
    input  logic              APB_S_0_psel,
    input  logic              APB_S_0_penable,
    input  logic              APB_S_0_pwrite,
    input  logic [31:0]       APB_S_0_pwdata,
    output logic [31:0]       APB_S_0_prdata,
    output logic              APB_S_0_pready,
    output logic              APB_S_0_pslverr,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_next,
    output logic              stream_done
);

    localparam int                LEN_W     = ADDR_W + 1;
    localparam logic [31:0]       DEPTH_W32 = 32'd1 << ADDR_W;
    localparam logic [LEN_W-1:0]  DEPTH_L   = LEN_W'(DEPTH_W32);

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] idx_r, idx_nxt_s;
    logic [LEN_W-1:0]  len_r, len_eff_s;
    logic              loop_r, done_r, stream_done_r;
    logic              pready_r, pslverr_r, mem_rd_r;
    logic [31:0]       reg_rdata_r, reg_rdata_s, ofs_s;
    logic              win_s, ctrl_hit_s, len_hit_s, stat_hit_s, unmapped_s;
    logic              acc_first_s, commit_s, wr_commit_s, mem_we_s;
    logic              start_s, stop_s, busy_s, last_s, end_s, start_ok_s;
    logic [ADDR_W-1:0] mem_idx_s, raddr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              unused_s;

    assign unused_s    = ^APB_S_0_paddr[31:APB_AW];

    assign win_s       = APB_S_0_paddr[APB_AW-1];
    assign ofs_s       = 32'(APB_S_0_paddr[APB_AW-2:0]);
    assign ctrl_hit_s  = !win_s && (ofs_s == CTRL_OFS);
    assign len_hit_s   = !win_s && (ofs_s == LEN_OFS);
    assign stat_hit_s  = !win_s && (ofs_s == STATUS_OFS);
    assign unmapped_s  = !(win_s || ctrl_hit_s || len_hit_s || stat_hit_s);
    assign mem_idx_s   = APB_S_0_paddr[ADDR_W+1:2];

    // Two access-phase cycles: the first arms pready, the second completes.
    assign acc_first_s = APB_S_0_psel && APB_S_0_penable && !pready_r;
    assign commit_s    = APB_S_0_psel && APB_S_0_penable && pready_r;
    assign wr_commit_s = commit_s && APB_S_0_pwrite;
    assign mem_we_s    = wr_commit_s && win_s;

    assign start_s     = wr_commit_s && ctrl_hit_s && APB_S_0_pwdata[CTRL_START_BIT];
    assign stop_s      = wr_commit_s && ctrl_hit_s && APB_S_0_pwdata[CTRL_STOP_BIT];
    assign start_ok_s  = (state_r == ST_IDLE) && start_s && !stop_s;

    assign busy_s      = (state_r != ST_IDLE);
    assign len_eff_s   = (len_r == {LEN_W{1'b0}}) ? DEPTH_L : len_r;
    assign last_s      = ({1'b0, idx_r} == (len_eff_s - LEN_W'(1)));

    // The stream owns the read port while busy so the next word is
    // fetched in the same cycle the index advances.
    assign raddr_s     = busy_s ? idx_nxt_s : mem_idx_s;

    stream_mem_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_idx_s),
        .wdata (APB_S_0_pwdata[DATA_W-1:0]),
        .raddr (raddr_s),
        .rdata (rd_data_s)
    );

    // Register read mux (memory reads come straight from the RAM output)
    always_comb begin
        reg_rdata_s = 32'd0;
        if (ctrl_hit_s) begin
            reg_rdata_s[CTRL_LOOP_BIT] = loop_r;
        end else if (len_hit_s) begin
            reg_rdata_s[LEN_W-1:0] = len_r;
        end else if (stat_hit_s) begin
            reg_rdata_s[STATUS_BUSY_BIT]              = busy_s;
            reg_rdata_s[STATUS_DONE_BIT]              = done_r;
            reg_rdata_s[STATUS_IDX_LSB +: ADDR_W]     = idx_r;
        end else begin
            reg_rdata_s = 32'd0;
        end
    end

    // Stream FSM next-state and index advance; STOP beats tx_next
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        end_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_PRIME;
                    idx_nxt_s   = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tx_next) begin
                    if (last_s) begin
                        idx_nxt_s = {ADDR_W{1'b0}};
                        if (!loop_r) begin
                            state_nxt_s = ST_IDLE;
                            end_s       = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        idx_nxt_s = idx_r + ADDR_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // APB handshake and registered response for the completing cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            mem_rd_r    <= 1'b0;
            reg_rdata_r <= 32'd0;
        end else begin
            pready_r    <= acc_first_s;
            pslverr_r   <= acc_first_s && (unmapped_s || (win_s && !APB_S_0_pwrite && busy_s));
            mem_rd_r    <= acc_first_s && win_s && !APB_S_0_pwrite && !busy_s;
            reg_rdata_r <= (acc_first_s && !APB_S_0_pwrite && !win_s) ? reg_rdata_s : 32'd0;
        end
    end

    // LEN (saturating at DEPTH) and LOOP configuration registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_r  <= {LEN_W{1'b0}};
            loop_r <= 1'b0;
        end else begin
            if (wr_commit_s && len_hit_s) begin
                len_r <= (APB_S_0_pwdata > DEPTH_W32) ? DEPTH_L : APB_S_0_pwdata[LEN_W-1:0];
            end
            if (wr_commit_s && ctrl_hit_s) begin
                loop_r <= APB_S_0_pwdata[CTRL_LOOP_BIT];
            end
        end
    end

    // FSM state, stream index, sticky DONE and the completion pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_IDLE;
            idx_r         <= {ADDR_W{1'b0}};
            done_r        <= 1'b0;
            stream_done_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            stream_done_r <= end_s;
            if (end_s) begin
                done_r <= 1'b1;
            end else if (start_ok_s) begin
                done_r <= 1'b0;
            end else if (wr_commit_s && stat_hit_s && APB_S_0_pwdata[STATUS_DONE_BIT]) begin
                done_r <= 1'b0;
            end
        end
    end

    assign APB_S_0_pready  = pready_r;
    assign APB_S_0_pslverr = pslverr_r;
    assign APB_S_0_prdata  = mem_rd_r ? 32'(rd_data_s) : reg_rdata_r;
    assign tx_en           = (state_r == ST_RUN);
    assign tx_data         = (state_r == ST_RUN) ? rd_data_s : {DATA_W{1'b0}};
    assign stream_done     = stream_done_r;

endmodule

// File: tb/tb_apb_stream_mem.sv
// Self-checking bench for apb_stream_mem: expected stream words are queued
// when a stream is started and popped as the consumer takes each word.
module tb_apb_stream_mem;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite, tx_next;
    logic [31:0] prdata;
    logic        pready, pslverr, tx_en, stream_done;
    logic [11:0] tx_data;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic        pulse_on_commit = 1'b0;
    logic [11:0] mem_model [0:127];
    logic [31:0] rd;
    logic        er;
    int          wt;

    apb_stream_mem #(.DATA_W(12), .ADDR_W(7), .APB_AW(12)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .APB_S_0_paddr   (paddr),
        .APB_S_0_psel    (psel),
        .APB_S_0_penable (penable),
        .APB_S_0_pwrite  (pwrite),
        .APB_S_0_pwdata  (pwdata),
        .APB_S_0_prdata  (prdata),
        .APB_S_0_pready  (pready),
        .APB_S_0_pslverr (pslverr),
        .tx_en           (tx_en),
        .tx_data         (tx_data),
        .tx_next         (tx_next),
        .stream_done     (stream_done)
    );

    always #5 clk = ~clk;

    // Count completion pulses away from the active edge
    always @(negedge clk) begin
        if (stream_done) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        psel    = 1'b1;
        penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        waits = 1;
        while (!pready && waits < 8) begin
            tick();
            waits++;
        end
        if (!pready) check_eq("apb_pready_timeout", 32'(pready), 32'd1);
        rdata = prdata;
        err   = pslverr;
        if (pulse_on_commit) tx_next = 1'b1;
        tick();
        tx_next = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_xfer(1'b1, addr, wdata, d, e, w);
        check_eq("wr_pslverr", 32'(e), 32'd0);
    endtask

    task automatic apb_read_chk(input string tag, input logic [31:0] addr,
                                input logic [31:0] exp, input logic exp_err);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_xfer(1'b0, addr, 32'd0, d, e, w);
        check_eq(tag, d, exp);
        check_eq({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    // Take n words: wait gap-1 cycles, compare against the scoreboard, pulse tx_next
    task automatic consume(input int n, input int gap, input bit pulse);
        logic [31:0] exp;
        for (int k = 0; k < n; k++) begin
            for (int g = 1; g < gap; g++) tick();
            check_eq("tx_en_run", 32'(tx_en), 32'd1);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check_eq("tx_data", 32'(tx_data), exp);
            if (pulse) begin
                tx_next = 1'b1;
                tick();
                tx_next = 1'b0;
            end
        end
    endtask

    initial begin
        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0; tx_next = 1'b0;
        #12;
        // Reset values
        check_eq("rst_tx_en", 32'(tx_en), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_stream_done", 32'(stream_done), 32'd0);
        check_eq("rst_pready", 32'(pready), 32'd0);
        check_eq("rst_pslverr", 32'(pslverr), 32'd0);
        check_eq("rst_prdata", prdata, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        tick();
        apb_read_chk("rst_status", 32'h008, 32'd0, 1'b0);
        apb_read_chk("rst_len", 32'h004, 32'd0, 1'b0);
        apb_read_chk("rst_ctrl", 32'h000, 32'd0, 1'b0);

        // One-shot stream of four words
        mem_model[0] = 12'h111; mem_model[1] = 12'h222;
        mem_model[2] = 12'h333; mem_model[3] = 12'h444;
        for (int i = 0; i < 4; i++) apb_write(32'h800 + 32'(4 * i), 32'(mem_model[i]));
        apb_write(32'h004, 32'd4);
        apb_write(32'h000, 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(mem_model[i]));
        apb_write(32'h000, 32'd1);
        tick();
        consume(4, 4, 1'b1);
        check_eq("oneshot_tx_en_drop", 32'(tx_en), 32'd0);
        check_eq("oneshot_done_pulse", 32'(stream_done), 32'd1);
        tick();
        check_eq("oneshot_done_low", 32'(stream_done), 32'd0);
        check_eq("oneshot_done_cnt", 32'(done_cnt), 32'd1);
        apb_read_chk("oneshot_status", 32'h008, 32'h2, 1'b0);
        apb_write(32'h008, 32'h2);
        apb_read_chk("done_cleared", 32'h008, 32'h0, 1'b0);

        // Loop mode, LEN=3, seven advances
        apb_write(32'h004, 32'd3);
        apb_write(32'h000, 32'd4);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(mem_model[i % 3]));
        apb_write(32'h000, 32'd5);
        tick();
        consume(7, 4, 1'b1);
        consume(1, 1, 1'b0);
        apb_read_chk("loop_status", 32'h008, 32'h0001_0001, 1'b0);

        // Error responses while busy / unmapped
        apb_read_chk("busy_mem_read", 32'h808, 32'd0, 1'b1);
        apb_read_chk("unmapped_read", 32'h00C, 32'd0, 1'b1);
        check_eq("busy_still_run", 32'(tx_en), 32'd1);

        // STOP coinciding with tx_next
        pulse_on_commit = 1'b1;
        apb_write(32'h000, 32'h6);
        pulse_on_commit = 1'b0;
        check_eq("stop_tx_en", 32'(tx_en), 32'd0);
        check_eq("stop_no_done", 32'(stream_done), 32'd0);
        tick();
        check_eq("stop_done_cnt", 32'(done_cnt), 32'd1);
        apb_read_chk("stop_status", 32'h008, 32'h0001_0000, 1'b0);
        check_eq("sb_empty_loop", 32'(exp_q.size()), 32'd0);

        // Idle memory read with timing
        apb_xfer(1'b0, 32'h808, 32'd0, rd, er, wt);
        check_eq("idle_mem_read", rd, 32'h333);
        check_eq("idle_mem_err", 32'(er), 32'd0);
        check_eq("idle_mem_pready_cycle", 32'(wt), 32'd1);

        // LEN saturation and full-depth one-shot
        apb_write(32'h004, 32'd300);
        apb_read_chk("len_sat", 32'h004, 32'd128, 1'b0);
        apb_write(32'h004, 32'd0);
        apb_read_chk("len_zero", 32'h004, 32'd0, 1'b0);
        for (int i = 0; i < 128; i++) begin
            mem_model[i] = 12'((i * 37 + 5) & 12'hFFF);
            apb_write(32'h800 + 32'(4 * i), 32'(mem_model[i]));
        end
        for (int i = 0; i < 128; i++) exp_q.push_back(32'(mem_model[i]));
        apb_write(32'h000, 32'd1);
        tick();
        consume(128, 1, 1'b1);
        check_eq("full_tx_en_drop", 32'(tx_en), 32'd0);
        check_eq("full_done_pulse", 32'(stream_done), 32'd1);
        tick();
        check_eq("full_done_cnt", 32'(done_cnt), 32'd2);
        check_eq("sb_empty_full", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during RUN
        apb_write(32'h000, 32'd1);
        tick();
        tick();
        check_eq("pre_rst_tx_en", 32'(tx_en), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_tx_en", 32'(tx_en), 32'd0);
        check_eq("midrst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        tick();
        apb_read_chk("post_rst_status", 32'h008, 32'd0, 1'b0);
        apb_read_chk("post_rst_len", 32'h004, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
